// File: rtl/fp_pkg.sv
// Shared types, constants and helpers for the single-precision add/sub sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMP   = 3'd1,
    ALIGN = 3'd2,
    ADD   = 3'd3,
    NORM  = 3'd4,
    DONE  = 3'd5
  } fsm_state_t;

  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam int          SIG_W      = 25;

  // Leading-zero count of a 24-bit significand; 24 when the value is zero.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_exp_diff.sv
// Exponent comparator: absolute difference, larger exponent, and which side is larger.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure logic).
module fp_exp_diff (
  input  logic [7:0] exp_a_i,
  input  logic [7:0] exp_b_i,
  output logic [7:0] diff_o,
  output logic [7:0] exp_max_o,
  output logic       a_larger_o
);

  // Strictly-greater flag; on a tie the caller breaks it on the fractions.
  always_comb begin
    a_larger_o = (exp_a_i > exp_b_i);
    if (a_larger_o) begin
      diff_o    = exp_a_i - exp_b_i;
      exp_max_o = exp_a_i;
    end else begin
      diff_o    = exp_b_i - exp_a_i;
      exp_max_o = exp_b_i;
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle FP32 add/sub: compare, iterative align, add, iterative normalize, truncate.
// Latency: 1 + ceil(shift/ALIGN_STEP) + 1 + norm cycles + 1; specials (FP_ADD_SPECIALS_EN) take 2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int ALIGN_STEP = 1,
  parameter int NORM_STEP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        busy
);

  localparam logic [4:0] ASTEP = 5'(ALIGN_STEP);
  localparam logic [4:0] NSTEP = 5'(NORM_STEP);

  fsm_state_t       state_q, state_d;
  fp32_t            a_q, a_d, b_q, b_d;
  logic             sign_x_q, sign_x_d, sign_y_q, sign_y_d;
  logic [SIG_W-1:0] sig_x_q, sig_x_d, sig_y_q, sig_y_d;
  logic [9:0]       exp_q, exp_d;
  logic [4:0]       shift_q, shift_d;
  logic [31:0]      result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       diff, exp_max;
  logic             a_larger, swap, finish, special;
  logic [31:0]      spec_res;
  logic [4:0]       lz, align_amt, norm_amt;
  logic [9:0]       fin_exp;
  logic [SIG_W-1:0] sig_sh;

  fp_exp_diff u_exp_diff (
    .exp_a_i   (a_q.exp),
    .exp_b_i   (b_q.exp),
    .diff_o    (diff),
    .exp_max_o (exp_max),
    .a_larger_o(a_larger)
  );

`ifdef FP_ADD_SPECIALS_EN
  // NaN/Inf/zero short-circuit; zero and denormals act as signed zero.
  always_comb begin
    special  = (a_q.exp == FP_EXP_MAX) || (b_q.exp == FP_EXP_MAX) ||
               (a_q.exp == 8'h00) || (b_q.exp == 8'h00);
    spec_res = '0;
    if ((a_q.exp == FP_EXP_MAX && a_q.frac != '0) || (b_q.exp == FP_EXP_MAX && b_q.frac != '0))
      spec_res = FP_QNAN;
    else if (a_q.exp == FP_EXP_MAX && b_q.exp == FP_EXP_MAX)
      spec_res = (a_q.sign != b_q.sign) ? FP_QNAN : a_q;
    else if (a_q.exp == FP_EXP_MAX)
      spec_res = a_q;
    else if (b_q.exp == FP_EXP_MAX)
      spec_res = b_q;
    else if (a_q.exp == 8'h00)
      spec_res = b_q;
    else
      spec_res = a_q;
  end
`else
  assign special  = 1'b0;
  assign spec_res = '0;
`endif

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_x_q <= 1'b0;
      sign_y_q <= 1'b0;
      sig_x_q  <= '0;
      sig_y_q  <= '0;
      exp_q    <= '0;
      shift_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_x_q <= sign_x_d;
      sign_y_q <= sign_y_d;
      sig_x_q  <= sig_x_d;
      sig_y_q  <= sig_y_d;
      exp_q    <= exp_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath: one stage of work per state per cycle.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_x_d  = sign_x_q;
    sign_y_d  = sign_y_q;
    sig_x_d   = sig_x_q;
    sig_y_d   = sig_y_q;
    exp_d     = exp_q;
    shift_d   = shift_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    swap      = 1'b0;
    finish    = 1'b0;
    fin_exp   = '0;
    sig_sh    = '0;
    lz        = lzc24(sig_x_q[23:0]);
    align_amt = (shift_q < ASTEP) ? shift_q : ASTEP;
    norm_amt  = (lz < NSTEP) ? lz : NSTEP;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = op_a;
          b_d      = op_b;
          b_d.sign = op_b[31] ^ sub;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (special) begin
          result_d = spec_res;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else begin
          // X is the larger magnitude, so X - Y can never go negative.
          swap = !a_larger && ((diff != 8'd0) || (b_q.frac > a_q.frac));
          if (swap) begin
            sign_x_d = b_q.sign;
            sig_x_d  = {2'b01, b_q.frac};
            sign_y_d = a_q.sign;
            sig_y_d  = {2'b01, a_q.frac};
          end else begin
            sign_x_d = a_q.sign;
            sig_x_d  = {2'b01, a_q.frac};
            sign_y_d = b_q.sign;
            sig_y_d  = {2'b01, b_q.frac};
          end
          exp_d   = {2'b00, exp_max};
          shift_d = (diff > 8'd25) ? 5'd25 : diff[4:0];
          state_d = (diff == 8'd0) ? ADD : ALIGN;
        end
      end
      ALIGN: begin
        sig_y_d = sig_y_q >> align_amt;
        shift_d = shift_q - align_amt;
        if (shift_q == align_amt) state_d = ADD;
      end
      ADD: begin
        sig_x_d = (sign_x_q == sign_y_q) ? (sig_x_q + sig_y_q) : (sig_x_q - sig_y_q);
        state_d = NORM;
      end
      NORM: begin
        if (sig_x_q == '0) begin
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else if (sig_x_q[SIG_W-1]) begin
          fin_exp = exp_q + 10'd1;
          sig_sh  = sig_x_q >> 1;
          finish  = 1'b1;
        end else if (norm_amt != 5'd0 && exp_q <= {5'b0, norm_amt}) begin
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end else begin
          fin_exp = exp_q - {5'b0, norm_amt};
          sig_sh  = sig_x_q << norm_amt;
          exp_d   = fin_exp;
          sig_x_d = sig_sh;
          finish  = (norm_amt == lz);
        end
        if (finish) begin
          if (fin_exp >= 10'd255) begin
            ovf_d    = 1'b1;
            result_d = {sign_x_q, FP_EXP_MAX, 23'h0};
          end else begin
            ovf_d    = 1'b0;
            result_d = {sign_x_q, fin_exp[7:0], sig_sh[22:0]};
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed-vector bench for fp_add_sequencer with hand-computed results and latencies.
// Latency: measured from the capture edge to the first cycle out_valid is seen.
// Backpressure: exercises a held DONE (out_ready low) and a mid-operation reset.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency, optionally hold DONE, then drain.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] exp_res, input logic exp_ovf,
                        input int exp_lat, input int hold);
    int   lat;
    logic seen;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, " out_valid seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold result"}, result, exp_res);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, " out_valid after accept"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int vld_cnt;
    #12;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result", result, 32'h0);
    chk("reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("1+1",        32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4, 5);
    run_op("1+0.5",      32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b0, 5, 0);
    run_op("3+-1",       32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 1'b0, 5, 0);
    run_op("1-1",        32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 4, 0);
    run_op("1.5-1.25",   32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 1'b0, 5, 0);
    run_op("2^24+1",     32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 28, 0);
    run_op("max+max",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4, 0);
`ifdef FP_ADD_SPECIALS_EN
    run_op("inf+-inf",   32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 2, 0);
    run_op("0+2",        32'h00000000, 32'h40000000, 1'b0, 32'h40000000, 1'b0, 2, 0);
`endif

    // Reset while the long alignment is in progress.
    @(negedge clk);
    op_a = 32'h4B800000; op_b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid-align busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-reset in_ready", 32'(in_ready), 32'd1);
    chk("mid-reset busy", 32'(busy), 32'd0);
    chk("mid-reset out_valid", 32'(out_valid), 32'd0);
    chk("mid-reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) vld_cnt++;
    end
    chk("post-reset no output", 32'(vld_cnt), 32'd0);
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
Multi-cycle controller and datapath for single-precision FP add/subtract. Sequences the adder stages: exponent compare, iterative mantissa alignment, add/sub, iterative normalization and truncation. Sits between the FP register-file read stage and writeback, with valid/ready handshakes on both sides. Owns the exponent-difference logic and the shared shifter.

Parameters:
ALIGN_STEP, 1, max right-shift bits per ALIGN cycle (1..25)
NORM_STEP, 1, max left-shift bits per NORM cycle (1..24)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
op_a  input  32  IEEE-754 single operand A
op_b  input  32  IEEE-754 single operand B
sub  input  1  1 = A - B, 0 = A + B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  32  IEEE-754 single result
overflow  output  1  exponent overflow flag, valid with out_valid
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready=1; out_valid=0; result=0; overflow=0; busy=0. Reset mid-operation discards the operation and produces no output.
- Operands are captured on a clk edge with in_valid && in_ready. For sub, B's sign is inverted at capture.
- Significands are {1'b1, frac} (24 bits), held in 25-bit working registers (carry bit).
- States: IDLE -> CMP -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
- CMP (1 cycle):
  - diff = |expA - expB| as 8-bit unsigned; exp_r = larger exponent.
  - Operands are swapped so the larger-magnitude operand is X. Compare exponents, then mantissas on a tie.
  - shift_cnt = min(diff, 25).
- ALIGN:
  - Each cycle, Y's significand shifts right by min(ALIGN_STEP, shift_cnt) and shift_cnt decrements by the same amount.
  - Exit to ADD when shift_cnt == 0; with diff=0, ALIGN takes 0 cycles.
  - Shifted-out bits are discarded (truncation); there are no guard or sticky bits.
- ADD (1 cycle):
  - Same signs: sum = X + Y.
  - Different signs: sum = X - Y, which is never negative because of the swap.
  - Result sign = sign of X.
- NORM:
  - If sum == 0: result = +0 (0x00000000); go to DONE.
  - If sum[24] is set: shift right 1 and increment exponent (1 cycle).
  - Else, while sum[23] == 0: each cycle shift left by min(NORM_STEP, leading zeros) and decrement exponent by the same amount.
  - Underflow: if the exponent would go below 1, result = +0.
- Overflow: if the exponent reaches 255, overflow=1 and result = {sign, 8'hFF, 23'h0}.
- DONE:
  - out_valid=1; result is stable until out_valid && out_ready.
  - On that edge: out_valid=0, state=IDLE.
  - in_ready stays 0 until the next cycle (no same-cycle turnaround).
- Latency, capture to out_valid = 1 (CMP) + ceil(shift_cnt/ALIGN_STEP) + 1 (ADD) + norm cycles + 1.
  - Example: 1.0+1.0 gives 4 cycles.
- in_valid while busy is ignored; the operands must be held by the producer.
- Rounding is truncation (toward zero) on the aligned operands.

Optional Feature:
FP_ADD_SPECIALS_EN
- Defined: CMP detects exp=255 and exp=0 operands and goes straight to DONE.
  - NaN in either operand -> 0x7FC00000.
  - Inf + (-Inf) -> 0x7FC00000.
  - Inf + x -> that Inf.
  - Zero/denormal operand (exp=0) is treated as signed zero, so the result is the other operand.
  - Special-case results take 2 cycles to out_valid.
- Undefined: exp 0 and 255 are treated as ordinary normal exponents with an implicit 1; no special detection.

Decomposition:
- Package fp_pkg:
  - typedef struct packed {sign, exp[7:0], frac[22:0]} fp32_t
  - enum fsm_state_t {IDLE, CMP, ALIGN, ADD, NORM, DONE}
  - localparams FP_EXP_MAX=8'hFF, FP_QNAN=32'h7FC00000, SIG_W=25
- One sub-module, fp_exp_diff: combinational |expA-expB|, larger exponent, a_larger flag. Instantiated in CMP.

Test Plan:
- 0x3F800000 + 0x3F800000, sub=0 -> result 0x40000000, overflow=0, out_valid 4 cycles after capture (defaults).
- 0x3F800000 + 0x3F000000 -> 0x3FC00000 (1.5); ALIGN takes exactly 1 cycle.
- 0x40400000 + 0xBF800000 -> 0x40000000 (3.0 + -1.0); then 0x3F800000 - 0x3F800000, sub=1 -> 0x00000000.
- 0x4B800000 + 0x3F800000 -> 0x4B800000 (addend fully shifted out); 0x7F7FFFFF + 0x7F7FFFFF -> overflow=1, result 0x7F800000.
- Hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0; assert rst_n low mid-ALIGN -> immediate IDLE, in_ready=1, no out_valid.
- With FP_ADD_SPECIALS_EN:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x00000000 + 0x40000000 -> 0x40000000.
  - Each in 2 cycles.
